lmem_arbiter: RTL and testbench

LMEM_ARBITER -- requirements
Module: lmem_arbiter

---
 rtl/lmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_lmem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lmem_arbiter.sv
// lmem_arbiter: grants one of three requesters (conv writer, pool, flatten
// writer) burst access to the single layer-memory port.
//
// Ports:
//   clk, reset                : clock, synchronous active-low reset
//   req/we/last [2:0]         : per-requester request, beat type (1=write), final beat
//   sel [8:0]                 : per-requester memory select, requester i at [3i+2:3i]
//   addr [3*ADDR_W-1:0]       : per-requester beat address
//   wdata [3*DATA_W-1:0]      : per-requester write data
//   gnt [2:0]                 : registered one-hot grant
//   rvalid [2:0], rdata       : read return, two cycles after the read beat is accepted
//   cwr/crd, caddr_wr/caddr_rd, cdata_wr, csel, cdata_rd : layer-memory port
//
// Build option: define LMEM_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (requester 0 highest); the round-robin pointer is then absent.
//
// state  | meaning
// S_IDLE | no owner; arbitrate among pending requests
// S_BUSY | owner holds gnt; each cycle with req[owner]=1 is an accepted beat
// S_TURN | one dead cycle with gnt=0 while the memory pipeline drains

module lmem_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 20,
   parameter int MAX_BURST = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [8:0]            sel,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   input  logic [2:0]            last,
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  cwr,
   output logic                  crd,
   output logic [ADDR_W-1:0]     caddr_wr,
   output logic [ADDR_W-1:0]     caddr_rd,
   output logic [DATA_W-1:0]     cdata_wr,
   output logic [2:0]            csel,
   input  logic [DATA_W-1:0]     cdata_rd
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_TURN} state_t;

   localparam logic [7:0] LP_LAST_CNT = 8'(MAX_BURST - 1);

   state_t              r_state, w_state_nxt;
   logic [1:0]          r_owner;
   logic [1:0]          w_pick;
   logic [7:0]          r_beat_cnt;
   logic [2:0]          r_gnt, w_gnt_nxt;
   logic                w_own_req, w_own_we, w_own_last, w_accept;
   logic [2:0]          w_own_sel;
   logic [ADDR_W-1:0]   w_own_addr;
   logic [DATA_W-1:0]   w_own_wdata;
   logic                r_cwr, r_crd;
   logic [ADDR_W-1:0]   r_caddr_wr, r_caddr_rd;
   logic [DATA_W-1:0]   r_cdata_wr;
   logic [2:0]          r_csel, r_rd_owner, r_rvalid;
`ifndef LMEM_ARB_FIXED_PRIO_EN
   logic [1:0]          r_rr_ptr;
`endif

   function automatic logic [2:0] f_onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   // Owner's view of the per-requester buses.
   always_comb begin
      w_own_req   = 1'b0;
      w_own_we    = 1'b0;
      w_own_last  = 1'b0;
      w_own_sel   = '0;
      w_own_addr  = '0;
      w_own_wdata = '0;
      case (r_owner)
         2'd0: begin
            w_own_req = req[0]; w_own_we = we[0]; w_own_last = last[0];
            w_own_sel = sel[2:0];
            w_own_addr = addr[ADDR_W-1:0];
            w_own_wdata = wdata[DATA_W-1:0];
         end
         2'd1: begin
            w_own_req = req[1]; w_own_we = we[1]; w_own_last = last[1];
            w_own_sel = sel[5:3];
            w_own_addr = addr[2*ADDR_W-1:ADDR_W];
            w_own_wdata = wdata[2*DATA_W-1:DATA_W];
         end
         2'd2: begin
            w_own_req = req[2]; w_own_we = we[2]; w_own_last = last[2];
            w_own_sel = sel[8:6];
            w_own_addr = addr[3*ADDR_W-1:2*ADDR_W];
            w_own_wdata = wdata[3*DATA_W-1:2*DATA_W];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_pick = 2'd0;
`ifdef LMEM_ARB_FIXED_PRIO_EN
      if (req[0])      w_pick = 2'd0;
      else if (req[1]) w_pick = 2'd1;
      else             w_pick = 2'd2;
`else
      // Search order starts at the pointer and wraps.
      case (r_rr_ptr)
         2'd1:    w_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
         2'd2:    w_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
         default: w_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      endcase
`endif
   end

   assign w_accept = (r_state == S_BUSY) && w_own_req;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = 3'b000;
      case (r_state)
         S_IDLE: if (|req) w_state_nxt = S_BUSY;
         S_BUSY: if (w_accept && (w_own_last || r_beat_cnt == LP_LAST_CNT))
                    w_state_nxt = S_TURN;
         S_TURN: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_state_nxt == S_BUSY)
         w_gnt_nxt = f_onehot((r_state == S_IDLE) ? w_pick : r_owner);
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_owner    <= 2'd0;
         r_beat_cnt <= 8'd0;
         r_gnt      <= 3'b000;
         r_cwr      <= 1'b0;
         r_crd      <= 1'b0;
         r_caddr_wr <= '0;
         r_caddr_rd <= '0;
         r_cdata_wr <= '0;
         r_csel     <= 3'b000;
         r_rd_owner <= 3'b000;
         r_rvalid   <= 3'b000;
      end else begin
         r_gnt <= w_gnt_nxt;
         if (r_state == S_IDLE && |req) begin
            r_owner    <= w_pick;
            r_beat_cnt <= 8'd0;
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
         end
         r_cwr <= w_accept & w_own_we;
         r_crd <= w_accept & ~w_own_we;
         if (w_accept) begin
            r_csel     <= w_own_sel;
            r_rd_owner <= f_onehot(r_owner);
            if (w_own_we) begin
               r_caddr_wr <= w_own_addr;
               r_cdata_wr <= w_own_wdata;
            end else begin
               r_caddr_rd <= w_own_addr;
            end
         end
         // Memory returns read data the cycle after the crd strobe.
         r_rvalid <= r_crd ? r_rd_owner : 3'b000;
      end
   end

`ifndef LMEM_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk) begin
      if (!reset)
         r_rr_ptr <= 2'd0;
      else if (r_state == S_BUSY && w_state_nxt == S_TURN)
         r_rr_ptr <= (r_owner == 2'd2) ? 2'd0 : r_owner + 2'd1;
   end
`endif

   assign gnt      = r_gnt;
   assign rvalid   = r_rvalid;
   assign rdata    = cdata_rd;
   assign cwr      = r_cwr;
   assign crd      = r_crd;
   assign caddr_wr = r_caddr_wr;
   assign caddr_rd = r_caddr_rd;
   assign cdata_wr = r_cdata_wr;
   assign csel     = r_csel;

endmodule

// File: tb/tb_lmem_arbiter.sv
module tb_lmem_arbiter;

   localparam int AW   = 12;
   localparam int DW   = 20;
   localparam int MAXB = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        req, we, last;
   logic [8:0]        sel;
   logic [3*AW-1:0]   addr;
   logic [3*DW-1:0]   wdata;
   logic [DW-1:0]     cdata_rd;
   logic [2:0]        gnt, rvalid, csel;
   logic [DW-1:0]     rdata, cdata_wr;
   logic              cwr, crd;
   logic [AW-1:0]     caddr_wr, caddr_rd;

   always #5 clk = ~clk;

   lmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .sel(sel), .addr(addr),
      .wdata(wdata), .last(last), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
      .cdata_wr(cdata_wr), .csel(csel), .cdata_rd(cdata_rd)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase 0 = free, 1 = burst in progress, 2 = gap cycle.
   int              m_phase = 0, m_owner = 0, m_ptr = 0, m_beats = 0;
   bit              s1_v = 0, s1_wr = 0;
   logic [AW-1:0]   s1_addr;
   logic [DW-1:0]   s1_data;
   logic [2:0]      s1_sel;
   int              s1_owner = 0, s2_owner = -1;

   function automatic int pick_owner();
`ifdef LMEM_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++) if (req[k]) return k;
`else
      for (int k = 0; k < 3; k++) if (req[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`endif
      return 0;
   endfunction

   task automatic model_step();
      if (reset === 1'b0) begin
         m_phase = 0; m_ptr = 0; m_beats = 0; m_owner = 0;
         s1_v = 0; s2_owner = -1;
         return;
      end
      s2_owner = (s1_v && !s1_wr) ? s1_owner : -1;
      s1_v = 0;
      case (m_phase)
         0: if (req != 3'b000) begin
               m_owner = pick_owner(); m_beats = 0; m_phase = 1;
            end
         1: if (req[m_owner]) begin
               s1_v = 1; s1_wr = we[m_owner]; s1_owner = m_owner;
               s1_addr = addr[m_owner*AW +: AW];
               s1_data = wdata[m_owner*DW +: DW];
               s1_sel  = sel[m_owner*3 +: 3];
               m_beats++;
               if (last[m_owner] || m_beats == MAXB) begin
                  m_phase = 2; m_ptr = (m_owner + 1) % 3;
               end
            end
         default: m_phase = 0;
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic check_model(input string tag);
      logic [2:0] eg, erv;
      eg  = (m_phase == 1) ? (3'b001 << m_owner) : 3'b000;
      erv = (s2_owner >= 0) ? (3'b001 << s2_owner) : 3'b000;
      chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
      chk({tag, "_cwr"}, 32'(cwr), 32'(s1_v && s1_wr));
      chk({tag, "_crd"}, 32'(crd), 32'(s1_v && !s1_wr));
      chk({tag, "_rvalid"}, 32'(rvalid), 32'(erv));
      if (s1_v && s1_wr) begin
         chk({tag, "_caddr_wr"}, 32'(caddr_wr), 32'(s1_addr));
         chk({tag, "_cdata_wr"}, 32'(cdata_wr), 32'(s1_data));
         chk({tag, "_csel_wr"}, 32'(csel), 32'(s1_sel));
      end
      if (s1_v && !s1_wr) begin
         chk({tag, "_caddr_rd"}, 32'(caddr_rd), 32'(s1_addr));
         chk({tag, "_csel_rd"}, 32'(csel), 32'(s1_sel));
      end
      if (s2_owner >= 0) chk({tag, "_rdata"}, 32'(rdata), 32'(cdata_rd));
      chk({tag, "_excl"}, 32'(cwr & crd), 32'd0);
      chk({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
   endtask

   typedef struct {
      logic            rst_n;
      logic [2:0]      req, we, last;
      logic [2:0]      e_gnt;
      logic            e_cwr, e_crd;
      logic [2:0]      e_rv;
      logic [AW-1:0]   e_addr;
      logic [DW-1:0]   e_data;
      logic [2:0]      e_sel;
      logic            e_zero;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [2:0] w,
                               input logic [2:0] l, input logic [2:0] g, input logic ew,
                               input logic er, input logic [2:0] rv, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [2:0] s, input logic z);
      vec_t v;
      v.rst_n = r; v.req = q; v.we = w; v.last = l; v.e_gnt = g; v.e_cwr = ew;
      v.e_crd = er; v.e_rv = rv; v.e_addr = a; v.e_data = d; v.e_sel = s; v.e_zero = z;
      return v;
   endfunction

   localparam logic [AW-1:0] A0 = 12'h010, A1 = 12'h0FF, A2 = 12'h200;
   localparam logic [DW-1:0] D0 = 20'h12345, D1 = 20'h11111, D2 = 20'h22222;
   localparam logic [DW-1:0] RD = 20'hABCDE;

   vec_t tbl[28];
   int   order[4];
   int   ng, beats_in, cyc;
   logic [2:0] prev_gnt;

   initial begin
      reset = 1'b0; req = '0; we = '0; last = '0;
      sel = {3'd3, 3'd2, 3'd1};
      addr = {A2, A1, A0};
      wdata = {D2, D1, D0};
      cdata_rd = RD;

      //           rst req     we      last    gnt     cwr crd rv      addr data sel zero
      tbl[0]  = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 1);
      tbl[1]  = mk(1, 3'b001, 3'b001, 3'b001, 3'b001, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[2]  = mk(1, 3'b001, 3'b001, 3'b001, 3'b000, 1, 0, 3'b000, A0, D0, 1, 0);
      tbl[3]  = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[4]  = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[5]  = mk(1, 3'b010, 3'b000, 3'b010, 3'b010, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[6]  = mk(1, 3'b010, 3'b000, 3'b010, 3'b000, 0, 1, 3'b000, A1, 0,  2, 0);
      tbl[7]  = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b010, 0,  0,  0, 0);
      tbl[8]  = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[9]  = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[10] = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 1, 0, 3'b000, A2, D2, 3, 0);
      tbl[11] = mk(1, 3'b000, 3'b100, 3'b100, 3'b100, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[12] = mk(1, 3'b000, 3'b100, 3'b100, 3'b100, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[13] = mk(1, 3'b000, 3'b100, 3'b000, 3'b100, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[14] = mk(1, 3'b100, 3'b100, 3'b100, 3'b000, 1, 0, 3'b000, A2, D2, 3, 0);
      tbl[15] = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[16] = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[17] = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 1, 0, 3'b000, A2, D2, 3, 0);
      tbl[18] = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 1, 0, 3'b000, A2, D2, 3, 0);
      tbl[19] = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 1, 0, 3'b000, A2, D2, 3, 0);
      tbl[20] = mk(1, 3'b100, 3'b100, 3'b000, 3'b000, 1, 0, 3'b000, A2, D2, 3, 0);
      tbl[21] = mk(1, 3'b100, 3'b100, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[22] = mk(1, 3'b100, 3'b100, 3'b000, 3'b100, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[23] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 1);
      tbl[24] = mk(1, 3'b001, 3'b000, 3'b001, 3'b001, 0, 0, 3'b000, 0,  0,  0, 0);
      tbl[25] = mk(1, 3'b001, 3'b000, 3'b001, 3'b000, 0, 1, 3'b000, A0, 0,  1, 0);
      tbl[26] = mk(0, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 1);
      tbl[27] = mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 3'b000, 0,  0,  0, 1);

      for (int i = 0; i < 28; i++) begin
         reset = tbl[i].rst_n; req = tbl[i].req; we = tbl[i].we; last = tbl[i].last;
         tick();
         chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
         chk($sformatf("row%0d_cwr", i), 32'(cwr), 32'(tbl[i].e_cwr));
         chk($sformatf("row%0d_crd", i), 32'(crd), 32'(tbl[i].e_crd));
         chk($sformatf("row%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].e_rv));
         if (tbl[i].e_cwr) begin
            chk($sformatf("row%0d_caddr_wr", i), 32'(caddr_wr), 32'(tbl[i].e_addr));
            chk($sformatf("row%0d_cdata_wr", i), 32'(cdata_wr), 32'(tbl[i].e_data));
            chk($sformatf("row%0d_csel", i), 32'(csel), 32'(tbl[i].e_sel));
         end
         if (tbl[i].e_crd) begin
            chk($sformatf("row%0d_caddr_rd", i), 32'(caddr_rd), 32'(tbl[i].e_addr));
            chk($sformatf("row%0d_csel", i), 32'(csel), 32'(tbl[i].e_sel));
         end
         if (tbl[i].e_rv != 3'b000)
            chk($sformatf("row%0d_rdata", i), 32'(rdata), 32'(RD));
         if (tbl[i].e_zero) begin
            chk($sformatf("row%0d_rst_caddr_wr", i), 32'(caddr_wr), 32'd0);
            chk($sformatf("row%0d_rst_caddr_rd", i), 32'(caddr_rd), 32'd0);
            chk($sformatf("row%0d_rst_cdata_wr", i), 32'(cdata_wr), 32'd0);
            chk($sformatf("row%0d_rst_csel", i), 32'(csel), 32'd0);
         end
      end

      // Contention: all three hold req, every burst ends on its second beat.
      reset = 1'b0; req = 3'b000; last = 3'b000; we = 3'b000;
      tick();
      reset = 1'b1; req = 3'b111;
      ng = 0; beats_in = 0; cyc = 0;
      while (ng < 4 && cyc < 60) begin
         last = (gnt != 3'b000 && beats_in == 1) ? 3'b111 : 3'b000;
         if (gnt != 3'b000) beats_in++;
         prev_gnt = gnt;
         tick();
         check_model("cont");
         if (prev_gnt != 3'b000 && gnt == 3'b000)
            chk("cont_burst_len", 32'(beats_in), 32'd2);
         if (prev_gnt == 3'b000 && gnt != 3'b000) begin
            order[ng] = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : (gnt == 3'b100) ? 2 : 9;
            ng++;
            beats_in = 0;
         end
         cyc++;
      end
      chk("cont_grants_seen", 32'(ng), 32'd4);
      for (int k = 0; k < ng; k++) begin
`ifdef LMEM_ARB_FIXED_PRIO_EN
         chk($sformatf("cont_order%0d", k), 32'(order[k]), 32'd0);
`else
         chk($sformatf("cont_order%0d", k), 32'(order[k]), 32'(k % 3));
`endif
      end

      // Randomized traffic against the model, with occasional resets.
      reset = 1'b0; req = 3'b000; last = 3'b000;
      tick();
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 199) != 0);
         req      = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         we       = 3'($urandom_range(0, 7));
         last     = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 2) == 0)};
         sel      = 9'($urandom());
         addr     = 36'({$urandom(), $urandom()});
         wdata    = 60'({$urandom(), $urandom()});
         cdata_rd = 20'($urandom());
         tick();
         check_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
